key_input_ctrl: RTL and testbench
=================================

KEY_INPUT_CTRL -- requirements
Module: key_input_ctrl

Interface
REQ-001 The block SHALL have parameter REPEAT_DELAY, default 20: frames a direction key is held before the first auto-repeat move; legal range 2..63.
REQ-002 The block SHALL have parameter REPEAT_RATE, default 6: frames between successive auto-repeat moves; legal range 1..63.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock, 50 MHz system clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port keycode, input, 16 bits: current USB keycode from the Nios system, where 0 means no key.
REQ-006 The block SHALL have port frame_clk, input, 1 bit: VGA vertical sync, sampled in the Clk domain.
REQ-007 The block SHALL have ports up, down, left, right, outputs, 1 bit each: one-hot move requests, each held for exactly one frame period.
REQ-008 The block SHALL have port frog_sel, output, 2 bits: active frog, where 0 is none and 1/2/3 are frogs 1/2/3.
REQ-009 The block SHALL have port last_dir, output, 4 bits: {left,up,down,right} one-hot of the last arrow key seen, for the LEDs.
REQ-010 The block SHALL have port move_count, output, 8 bits: saturating count of move pulses issued, for the HEX display.

Function
REQ-011 Key decode SHALL compare the full 16 bits: 16'h50 left, 16'h4F right, 16'h52 up, 16'h51 down; 16'h59/5A/5B select frogs 1/2/3; all other codes are non-direction.
REQ-012 Frame edge detection: frame_edge = frame_clk & ~frame_clk_q, where frame_clk_q is a 1-cycle register of frame_clk.
REQ-013 The direction FSM SHALL advance only on Clk cycles where frame_edge=1; it SHALL use keycode as sampled in that same cycle.
REQ-014 FSM states SHALL be IDLE, HOLD and REPEAT; registers SHALL be held_dir[1:0] and a 6-bit frame counter cnt.
REQ-015 In IDLE with a direction key present, the FSM SHALL issue a move of that direction, set held_dir, clear cnt and go to HOLD.
REQ-016 In HOLD with the same key present: if cnt==REPEAT_DELAY-1, the FSM SHALL issue a move, clear cnt and go to REPEAT; otherwise it SHALL increment cnt.
REQ-017 In REPEAT with the same key present: if cnt==REPEAT_RATE-1, the FSM SHALL issue a move and clear cnt; otherwise it SHALL increment cnt.
REQ-018 In HOLD or REPEAT with a different direction key present, the FSM SHALL immediately issue a move of the new direction, update held_dir, clear cnt and go to HOLD.
REQ-019 In any state with a non-direction key or 0 present, the FSM SHALL go to IDLE, clear cnt and issue no move.
REQ-020 Move issue SHALL drive the matching up/down/left/right output to 1 and the others to 0, registered on the frame_edge cycle and held until the next frame_edge; outputs are never more than one-hot.
REQ-021 Every frame_edge that issues no move SHALL drive all four move outputs to 0.
REQ-022 Latency: a move output SHALL rise 1 Clk cycle after the frame_edge cycle; the downstream frog logic samples it on the following frame_clk rising edge.
REQ-023 frog_sel SHALL update every Clk cycle (not frame-gated) when keycode is 59/5A/5B, and SHALL hold its value for every other code including 0.
REQ-024 last_dir SHALL update every Clk cycle to the one-hot of any arrow code, and SHALL hold its value otherwise.
REQ-025 move_count SHALL increment by 1 per issued move, saturate at 255 and never wrap.
REQ-026 A frog-select key and frame_edge in the same cycle SHALL be handled independently: frog_sel updates and the FSM treats the select key as non-direction (REQ-019).

Reset
REQ-027 On Reset=1 at a Clk edge, the following SHALL be cleared: FSM=IDLE, cnt=0, held_dir=0, up/down/left/right=0, frog_sel=0, last_dir=0, move_count=0.
REQ-028 On Reset, frame_clk_q SHALL load 1 so that a high frame_clk at reset release produces no spurious edge.
REQ-029 Reset asserted mid-HOLD/REPEAT SHALL abort the sequence; a key still held after release SHALL be treated as a fresh press at the next frame_edge.

Configuration
REQ-030 The macro KEY_AUTOREPEAT_EN, when defined, SHALL enable the REPEAT behaviour exactly as in REQ-016/017.
REQ-031 When KEY_AUTOREPEAT_EN is undefined, HOLD SHALL never transition to REPEAT, cnt is unused, and a held key yields exactly one move per press; REPEAT_DELAY and REPEAT_RATE SHALL be ignored.

Verification
REQ-032 Scenario 1: Reset, then keycode=16'h52 held for 1 frame -> up=1 for exactly one frame period, starting 1 Clk after frame_edge; move_count=1; last_dir=4'b0100.
REQ-033 Scenario 2 (KEY_AUTOREPEAT_EN defined, defaults): keycode=16'h50 held for 40 frames -> left pulses on frames 0, 20, 26, 32, 38; move_count=5.
REQ-034 Scenario 3: keycode 16'h4F for 3 frames, then 16'h51 -> right on frame 0, down on frame 3, no overlap, FSM in HOLD.
REQ-035 Scenario 4: keycode=16'h5A then 0 then 16'h1234 -> frog_sel=2 and held; no move outputs.
REQ-036 Scenario 5: Reset during REPEAT with frame_clk high and the key held -> all outputs 0, no move on release cycle, move on the next frame_edge.
REQ-037 Scenario 6 (KEY_AUTOREPEAT_EN undefined): keycode=16'h51 held for 300 frames -> exactly 1 down pulse; move_count saturates at 255 after 300 separate presses.

Source files
------------

// File: rtl/key_input_ctrl.sv
//------------------------------------------------------------------------------
// Module      : key_input_ctrl
// Description : USB keycode to frame-paced frog move pulses, frog select,
//               LED direction and saturating move counter.
//               Optional macro KEY_AUTOREPEAT_EN enables held-key auto-repeat.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_input_ctrl #(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic        frame_clk,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic [1:0]  frog_sel,
  output logic [3:0]  last_dir,
  output logic [7:0]  move_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  localparam logic [1:0] c_dir_left  = 2'd0;
  localparam logic [1:0] c_dir_right = 2'd1;
  localparam logic [1:0] c_dir_up    = 2'd2;
  localparam logic [1:0] c_dir_down  = 2'd3;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [5:0] c_delay_last = 6'(REPEAT_DELAY - 1);
  localparam logic [5:0] c_rate_last  = 6'(REPEAT_RATE - 1);
  logic [5:0] r_cnt;
`endif

  state_t     r_state;
  logic [1:0] r_held_dir;
  logic       r_frame_clk_q;
  logic [3:0] r_move;      // {left, up, down, right}
  logic [1:0] r_frog_sel;
  logic [3:0] r_last_dir;
  logic [7:0] r_move_count;

  logic       w_frame_edge;
  logic       w_is_dir;
  logic [1:0] w_dir;

  assign w_frame_edge = frame_clk & ~r_frame_clk_q;

  always_comb begin
    w_is_dir = 1'b1;
    w_dir    = c_dir_left;
    case (keycode)
      16'h0050: w_dir = c_dir_left;
      16'h004F: w_dir = c_dir_right;
      16'h0052: w_dir = c_dir_up;
      16'h0051: w_dir = c_dir_down;
      default:  w_is_dir = 1'b0;
    endcase
  end

  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    case (dir)
      c_dir_left:  dir_onehot = 4'b1000;
      c_dir_up:    dir_onehot = 4'b0100;
      c_dir_down:  dir_onehot = 4'b0010;
      default:     dir_onehot = 4'b0001;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    sat_inc = (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_held_dir    <= 2'd0;
      r_frame_clk_q <= 1'b1;  // high frame_clk at release must not look like an edge
      r_move        <= 4'b0000;
      r_frog_sel    <= 2'd0;
      r_last_dir    <= 4'b0000;
      r_move_count  <= 8'd0;
`ifdef KEY_AUTOREPEAT_EN
      r_cnt         <= 6'd0;
`endif
    end else begin
      r_frame_clk_q <= frame_clk;

      case (keycode)
        16'h0059: r_frog_sel <= 2'd1;
        16'h005A: r_frog_sel <= 2'd2;
        16'h005B: r_frog_sel <= 2'd3;
        default:  r_frog_sel <= r_frog_sel;
      endcase

      if (w_is_dir) r_last_dir <= dir_onehot(w_dir);

      if (w_frame_edge) begin
        r_move <= 4'b0000;
        if (!w_is_dir) begin
          r_state <= S_IDLE;
`ifdef KEY_AUTOREPEAT_EN
          r_cnt   <= 6'd0;
`endif
        end else if (r_state == S_IDLE || w_dir != r_held_dir) begin
          // fresh press or direction change: move now and restart the hold timer
          r_move       <= dir_onehot(w_dir);
          r_held_dir   <= w_dir;
          r_state      <= S_HOLD;
          r_move_count <= sat_inc(r_move_count);
`ifdef KEY_AUTOREPEAT_EN
          r_cnt        <= 6'd0;
`endif
        end else begin
`ifdef KEY_AUTOREPEAT_EN
          if (r_state == S_HOLD) begin
            if (r_cnt == c_delay_last) begin
              r_move       <= dir_onehot(w_dir);
              r_move_count <= sat_inc(r_move_count);
              r_cnt        <= 6'd0;
              r_state      <= S_REPEAT;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end else begin
            if (r_cnt == c_rate_last) begin
              r_move       <= dir_onehot(w_dir);
              r_move_count <= sat_inc(r_move_count);
              r_cnt        <= 6'd0;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
`endif
        end
      end
    end
  end

  assign left       = r_move[3];
  assign up         = r_move[2];
  assign down       = r_move[1];
  assign right      = r_move[0];
  assign frog_sel   = r_frog_sel;
  assign last_dir   = r_last_dir;
  assign move_count = r_move_count;

endmodule

`default_nettype wire

// File: tb/tb_key_input_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_key_input_ctrl
// Description : Directed bench for key_input_ctrl with a frame-age reference
//               model compared every cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_input_ctrl;

  localparam int c_delay = 20;
  localparam int c_rate  = 6;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit c_ar = 1'b1;
`else
  localparam bit c_ar = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] keycode = 16'h0;
  logic        frame_clk = 1'b0;
  logic        up, down, left, right;
  logic [1:0]  frog_sel;
  logic [3:0]  last_dir;
  logic [7:0]  move_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  key_input_ctrl #(.REPEAT_DELAY(c_delay), .REPEAT_RATE(c_rate)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
    .up(up), .down(down), .left(left), .right(right),
    .frog_sel(frog_sel), .last_dir(last_dir), .move_count(move_count)
  );

  always #5 Clk = ~Clk;

  // Model: moves depend only on how many frames a direction has been held.
  bit         m_fq;
  int         m_dir;
  int         m_age;
  logic [3:0] m_move;
  logic [7:0] m_count;
  logic [1:0] m_frog;
  logic [3:0] m_last;

  function automatic int decode(input logic [15:0] k);
    case (k)
      16'h50:  return 3;
      16'h52:  return 2;
      16'h51:  return 1;
      16'h4F:  return 0;
      default: return -1;
    endcase
  endfunction

  function automatic bit repeat_due(input int age);
    if (!c_ar) return 1'b0;
    if (age == c_delay) return 1'b1;
    return (age > c_delay) && (((age - c_delay) % c_rate) == 0);
  endfunction

  always @(posedge Clk) begin
    int  d;
    bit  issue;
    d = decode(keycode);
    if (Reset) begin
      m_fq <= 1'b1; m_dir <= -1; m_age <= 0; m_move <= 4'b0;
      m_count <= 8'd0; m_frog <= 2'd0; m_last <= 4'b0;
    end else begin
      m_fq <= frame_clk;
      if (keycode == 16'h59) m_frog <= 2'd1;
      if (keycode == 16'h5A) m_frog <= 2'd2;
      if (keycode == 16'h5B) m_frog <= 2'd3;
      if (d >= 0) m_last <= 4'(1 << d);
      if (frame_clk && !m_fq) begin
        issue = 1'b0;
        if (d < 0) begin
          m_dir <= -1;
        end else if (d != m_dir) begin
          m_dir <= d; m_age <= 0; issue = 1'b1;
        end else begin
          m_age <= m_age + 1; issue = repeat_due(m_age + 1);
        end
        m_move <= issue ? 4'(1 << d) : 4'b0;
        if (issue && m_count != 8'hFF) m_count <= m_count + 8'd1;
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      checks++;
      if ({left, up, down, right} !== m_move || frog_sel !== m_frog ||
          last_dir !== m_last || move_count !== m_count) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual moves=%b frog=%0d last=%b cnt=%0d required moves=%b frog=%0d last=%b cnt=%0d",
                 $time, {left, up, down, right}, frog_sel, last_dir, move_count,
                 m_move, m_frog, m_last, m_count);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // One frame: frame_clk high 4 cycles, low 4 cycles.
  task automatic do_frame();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    @(negedge Clk); @(negedge Clk);
    cmp_en = 1'b1;
    check("reset_moves", {left, up, down, right}, 0);
    check("reset_count", move_count, 0);
    check("reset_frog", frog_sel, 0);
    check("reset_last", last_dir, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Scenario 1: single up press; move appears one cycle after the edge
    keycode = 16'h52;
    frame_clk = 1'b1;
    @(negedge Clk);
    check("s1_up_latency", up, 1);
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    check("s1_up_held", up, 1);
    check("s1_count", move_count, 1);
    check("s1_last", last_dir, 4'b0100);
    keycode = 16'h0;
    do_frame();
    check("s1_up_cleared", up, 0);

    // Scenario 3: right then down, no overlap
    keycode = 16'h4F;
    do_frame();
    check("s3_right", {left, up, down, right}, 4'b0001);
    do_frame(); do_frame();
    keycode = 16'h51;
    do_frame();
    check("s3_down", {left, up, down, right}, 4'b0010);
    check("s3_count", move_count, 3);
    do_frame();
    check("s3_down_hold", down, 0);

    // Scenario 4: frog select held through 0 and unknown codes
    keycode = 16'h5A;
    do_frame();
    check("s4_frog", frog_sel, 2);
    check("s4_nomove", {left, up, down, right}, 0);
    keycode = 16'h0;
    do_frame();
    keycode = 16'h1234;
    do_frame();
    check("s4_frog_held", frog_sel, 2);
    check("s4_last_held", last_dir, 4'b0010);
    keycode = 16'h0;

`ifdef KEY_AUTOREPEAT_EN
    // Scenario 2: auto-repeat cadence 0,20,26,32,38
    do_reset();
    keycode = 16'h50;
    pulses = 0;
    for (int f = 0; f < 40; f++) begin
      do_frame();
      if (left) pulses |= (f == 0 || f == 20 || f == 26 || f == 32 || f == 38) ? 0 : 32'h8000_0000;
      if (left) pulses++;
    end
    check("s2_pulses", pulses, 5);
    check("s2_count", move_count, 5);
    keycode = 16'h0;
    do_frame();
`endif

    // Scenario 5: reset with frame_clk high and key held
    do_reset();
    keycode = 16'h4F;
    repeat (c_ar ? 22 : 3) do_frame();
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("s5_reset_moves", {left, up, down, right}, 0);
    check("s5_reset_count", move_count, 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("s5_release_nomove", right, 0);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    do_frame();
    check("s5_fresh_press", right, 1);
    check("s5_count", move_count, 1);
    keycode = 16'h0;
    do_frame();

    // Scenario 6: long hold, then saturation over many presses
    do_reset();
    keycode = 16'h51;
    pulses = 0;
    for (int f = 0; f < 300; f++) begin
      do_frame();
      if (down) pulses++;
    end
`ifndef KEY_AUTOREPEAT_EN
    check("s6_single_pulse", pulses, 1);
`endif
    keycode = 16'h0;
    do_frame();
    for (int p = 0; p < 300; p++) begin
      keycode = 16'h51;
      do_frame();
      keycode = 16'h0;
      do_frame();
    end
    check("s6_saturate", move_count, 255);

    repeat (2) @(negedge Clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
